// File: rtl/param_shift_accumulator.sv
// WIDTH-bit accumulator shift register with parallel load, four shift modes
// (shift right/left, rotate right, LSB-first serial add) and a saturating shift counter.
module param_shift_accumulator #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LE,
  input  logic [WIDTH-1:0] Load,
  input  logic             SE,
  input  logic [1:0]       MODE,
  input  logic             Si,
  input  logic             PoutE,
  output logic             Sout,
  output logic [WIDTH-1:0] Pout,
  output logic             Cout,
  output logic             Done,
  output logic [CNT_W-1:0] Count
);

  localparam logic [1:0] MODE_SHR = 2'b00;
  localparam logic [1:0] MODE_SHL = 2'b01;
  localparam logic [1:0] MODE_ADD = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (WIDTH < 2) begin : g_width_check
    $error("param_shift_accumulator: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             done;
  logic             sum_bit;
  logic             carry_next;

  assign done       = (cnt == CNT_FULL);
  assign sum_bit    = r[0] ^ Si ^ c;
  assign carry_next = (r[0] & Si) | (r[0] & c) | (Si & c);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r   <= '0;
      cnt <= '0;
      c   <= 1'b0;
    end else if (LE) begin
      r   <= Load;
      cnt <= '0;
      c   <= 1'b0;
    end else if (SE && !done) begin
      // Count saturates at WIDTH because further shifts are blocked by done.
      cnt <= cnt + CNT_ONE;
      case (MODE)
        MODE_SHR: r <= {Si, r[WIDTH-1:1]};
        MODE_SHL: r <= {r[WIDTH-2:0], Si};
        MODE_ADD: begin
          r <= {sum_bit, r[WIDTH-1:1]};
          c <= carry_next;
        end
        MODE_ROR: r <= {r[0], r[WIDTH-1:1]};
        default:  r <= r;
      endcase
    end
  end

  // Sout is the bit that will leave the register on the next shift.
  assign Sout  = (MODE == MODE_SHL) ? r[WIDTH-1] : r[0];
  assign Pout  = PoutE ? r : '0;
  assign Cout  = c;
  assign Done  = done;
  assign Count = cnt;

endmodule
